// File: rtl/fibo_sched_pkg.sv
// Shared types and default sizing for the Fibonacci request scheduler.
// The scheduler shares one Fibonacci engine between several round-robin requesters.
package fibo_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_IDX_W       = 10;
    localparam int DEF_RES_W       = 16;
    // F(24) = 46368 is the last Fibonacci number below 2**16; F(25) = 75025 overflows.
    localparam int DEF_MAX_IDX     = 24;
    // The engine needs about 165 cycles in the worst case, so 255 leaves margin.
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int DEF_ABORT_CYC   = 2;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/fibo_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request after the last winner and
// moves the pointer only when the grant is actually taken.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [GW-1:0]    grant_idx,
    output logic             grant_any
);

    logic [GW-1:0] ptr_q;

    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_any && req[GW'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = GW'(cand);
            end
        end
        grant = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

    // Starting at N_REQ-1 makes requester 0 the first in line after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= GW'(N_REQ - 1);
        end else if (en && grant_any) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/fibo_request_scheduler.sv
// Shares one Fibonacci engine between N_REQ requesters: arbitrates, issues, times out
// a hung engine, and routes the result (or an error) back to the owning requester.
module fibo_request_scheduler
    import fibo_sched_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int RES_W       = DEF_RES_W,
    parameter int MAX_IDX     = DEF_MAX_IDX,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int ABORT_CYC   = DEF_ABORT_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]       req_ack,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [RES_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   fibo_start,
    output logic [IDX_W-1:0]       fibo_idx,
    output logic                   fibo_rst,
    input  logic [RES_W-1:0]       fibo_result,
    input  logic                   fibo_done
);

    localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t state_q, state_d;

    logic [N_REQ-1:0] grant;
    logic [GW-1:0]    grant_idx;
    logic             grant_any;
    logic             grant_en;
    logic [IDX_W-1:0] sel_idx;
    logic             idx_ok;
    logic             timeout_hit;
    logic             abort_end;

    logic [GW-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0] idx_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [N_REQ-1:0] ack_d, rsp_valid_d;
    logic [RES_W-1:0] rsp_data_d;
    logic             rsp_err_d, busy_d, start_d, frst_d;

    assign grant_en    = (state_q == ST_IDLE) && grant_any;
    assign sel_idx     = req_idx[int'(grant_idx) * IDX_W +: IDX_W];
    assign idx_ok      = (sel_idx <= IDX_W'(MAX_IDX));
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign abort_end   = (timer_q == TMR_W'(ABORT_CYC - 1));

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done is checked before the timer so a completion on the last allowed cycle still counts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = idx_ok ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (fibo_done) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (abort_end) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Owner, index, result and timer; the timer is reused to pace the abort pulse.
    always_comb begin
        owner_d  = owner_q;
        idx_d    = fibo_idx;
        result_d = result_q;
        err_d    = err_q;
        timer_d  = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    owner_d  = grant_idx;
                    idx_d    = sel_idx;
                    result_d = '0;
                    err_d    = idx_ok ? RESP_OK : RESP_ERR;
                    timer_d  = '0;
                end
            end
            ST_ISSUE: timer_d = '0;
            ST_WAIT: begin
                if (fibo_done) begin
                    result_d = fibo_result;
                    err_d    = RESP_OK;
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = RESP_ERR;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ABORT: timer_d = timer_q + 1'b1;
            default: ;
        endcase
    end

    // Output values for the state being entered; they are registered below.
    always_comb begin
        ack_d       = grant_en ? grant : '0;
        rsp_valid_d = (state_d == ST_RESP) ? (N_REQ'(1) << owner_d) : '0;
        rsp_data_d  = (state_d == ST_RESP) ? result_d : '0;
        rsp_err_d   = (state_d == ST_RESP) ? err_d : RESP_OK;
        busy_d      = (state_d != ST_IDLE);
        start_d     = (state_d == ST_ISSUE);
        frst_d      = (state_d != ST_ABORT);
    end

    // fibo_rst resets low, so the engine is held in reset for as long as rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= '0;
            fibo_idx   <= '0;
            result_q   <= '0;
            err_q      <= RESP_OK;
            timer_q    <= '0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            fibo_start <= 1'b0;
            fibo_rst   <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            fibo_idx   <= idx_d;
            result_q   <= result_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            req_ack    <= ack_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_err    <= rsp_err_d;
            busy       <= busy_d;
            fibo_start <= start_d;
            fibo_rst   <= frst_d;
        end
    end

endmodule

// File: tb/tb_fibo_request_scheduler.sv
// Directed bench for fibo_request_scheduler with a behavioural engine stub whose
// latency can be set per scenario or made to hang.
module tb_fibo_request_scheduler;

    localparam int N_REQ = 4;
    localparam int IDX_W = 10;
    localparam int RES_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*IDX_W-1:0] req_idx;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       rsp_valid;
    logic [RES_W-1:0]       rsp_data;
    logic                   rsp_err;
    logic                   busy;
    logic                   fibo_start;
    logic [IDX_W-1:0]       fibo_idx;
    logic                   fibo_rst;
    logic [RES_W-1:0]       fibo_result = '0;
    logic                   fibo_done = 1'b0;

    always #5 clk = ~clk;

    fibo_request_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_idx     (req_idx),
        .req_ack     (req_ack),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .fibo_start  (fibo_start),
        .fibo_idx    (fibo_idx),
        .fibo_rst    (fibo_rst),
        .fibo_result (fibo_result),
        .fibo_done   (fibo_done)
    );

    // Engine stub: done rises eng_lat cycles after the cycle in which fibo_start is high.
    int               eng_lat  = 5;
    bit               eng_hang = 1'b0;
    logic             eng_busy = 1'b0;
    int               eng_cnt  = 0;
    logic [RES_W-1:0] eng_res  = '0;

    function automatic logic [RES_W-1:0] fib(input logic [IDX_W-1:0] n);
        logic [RES_W-1:0] a, b, t;
        a = '0;
        b = 16'd1;
        for (int k = 0; k < int'(n); k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk or negedge fibo_rst) begin
        if (!fibo_rst) begin
            eng_busy  <= 1'b0;
            eng_cnt   <= 0;
            fibo_done <= 1'b0;
        end else begin
            fibo_done <= 1'b0;
            if (fibo_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 2;
                eng_res  <= fib(fibo_idx);
            end else if (eng_busy && !eng_hang) begin
                if (eng_cnt == eng_lat) begin
                    fibo_done   <= 1'b1;
                    fibo_result <= eng_res;
                    eng_busy    <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        int               owner;
        logic [RES_W-1:0] data;
        logic             err;
        int               cyc;
    } rsp_t;

    rsp_t rsp_q[$];
    int   ack_order[$];
    int   n_ack[N_REQ];
    int   n_start, n_frst_low, n_rsp, n_multi, cyc;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic clear();
        rsp_q.delete();
        ack_order.delete();
        foreach (n_ack[i]) n_ack[i] = 0;
        n_start = 0; n_frst_low = 0; n_rsp = 0; n_multi = 0; cyc = 0;
    endtask

    // One cycle: sample outputs on the falling edge; a requester drops its request once acked.
    task automatic step();
        rsp_t r;
        @(negedge clk);
        cyc++;
        if (fibo_start === 1'b1) n_start++;
        if (fibo_rst === 1'b0) n_frst_low++;
        if ($countones(req_ack) > 1 || $countones(rsp_valid) > 1) n_multi++;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ack[i] === 1'b1) begin
                n_ack[i]++;
                ack_order.push_back(i);
                req_valid[i] = 1'b0;
            end
            if (rsp_valid[i] === 1'b1) begin
                r.owner = i; r.data = rsp_data; r.err = rsp_err; r.cyc = cyc;
                rsp_q.push_back(r);
                n_rsp++;
            end
        end
    endtask

    function automatic rsp_t rsp_at(input int i);
        rsp_t r;
        r.owner = -1; r.data = 'x; r.err = 1'bx; r.cyc = -1;
        return (i < rsp_q.size()) ? rsp_q[i] : r;
    endfunction

    task automatic wait_rsp(input int target, input int budget, input string tag);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            step();
            k++;
        end
        n_total++;
        if (n_rsp < target) $display("FAIL %s_rsp_wait: got %0d responses, need %0d within %0d cycles", tag, n_rsp, target, budget);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear();
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_idx = '0;
        repeat (2) @(negedge clk);
        n_total++; if (req_ack !== 4'b0)    $display("FAIL rst_ack: got %b expected 0000", req_ack); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0)  $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 16'd0)  $display("FAIL rst_rsp_data: got %0d expected 0", rsp_data); else n_pass++;
        n_total++; if (rsp_err !== 1'b0)    $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); else n_pass++;
        n_total++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (fibo_start !== 1'b0) $display("FAIL rst_start: got %b expected 0", fibo_start); else n_pass++;
        n_total++; if (fibo_idx !== 10'd0)  $display("FAIL rst_idx: got %0d expected 0", fibo_idx); else n_pass++;
        n_total++; if (fibo_rst !== 1'b0)   $display("FAIL rst_fibo_rst: got %b expected 0", fibo_rst); else n_pass++;
        rst = 1'b1;
        clear();
        step();
        n_total++; if (fibo_rst !== 1'b1)   $display("FAIL post_rst_fibo_rst: got %b expected 1", fibo_rst); else n_pass++;
        n_total++; if (busy !== 1'b0)       $display("FAIL post_rst_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        rsp_t r;
        clear();
        eng_lat = 5; eng_hang = 1'b0;
        req_idx[0*IDX_W +: IDX_W] = 10'd10;
        req_valid[0] = 1'b1;
        wait_rsp(1, 40, "single");
        r = rsp_at(0);
        n_total++; if (r.owner !== 0)       $display("FAIL single_owner: got %0d expected 0", r.owner); else n_pass++;
        n_total++; if (r.data !== 16'd55)   $display("FAIL single_data: got %0d expected 55", r.data); else n_pass++;
        n_total++; if (r.err !== 1'b0)      $display("FAIL single_err: got %b expected 0", r.err); else n_pass++;
        // Grant edge, ISSUE cycle, 5 engine cycles, then RESP: seen at falling edge 7.
        n_total++; if (r.cyc !== 7)         $display("FAIL single_latency: got %0d expected 7", r.cyc); else n_pass++;
        repeat (4) step();
        n_total++; if (n_ack[0] !== 1)      $display("FAIL single_ack_count: got %0d expected 1", n_ack[0]); else n_pass++;
        n_total++; if (n_start !== 1)       $display("FAIL single_start_count: got %0d expected 1", n_start); else n_pass++;
        n_total++; if (n_rsp !== 1)         $display("FAIL single_rsp_count: got %0d expected 1", n_rsp); else n_pass++;
        n_total++; if (busy !== 1'b0)       $display("FAIL single_idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_all_four();
        rsp_t r;
        int   exp_data[4] = '{6765, 46368, 0, 1};
        int   a;
        do_reset();
        eng_lat = 3;
        req_idx = {10'd1, 10'd0, 10'd24, 10'd20};
        req_valid = 4'b1111;
        wait_rsp(4, 200, "all4");
        for (int i = 0; i < 4; i++) begin
            r = rsp_at(i);
            a = (i < ack_order.size()) ? ack_order[i] : -1;
            n_total++; if (a !== i) $display("FAIL all4_grant_order[%0d]: got %0d expected %0d", i, a, i); else n_pass++;
            n_total++;
            if (r.owner !== i || r.data !== RES_W'(exp_data[i]) || r.err !== 1'b0)
                $display("FAIL all4_rsp[%0d]: got owner %0d data %0d err %b expected owner %0d data %0d err 0", i, r.owner, r.data, r.err, i, exp_data[i]);
            else n_pass++;
        end
        n_total++; if (n_start !== 4) $display("FAIL all4_start_count: got %0d expected 4", n_start); else n_pass++;
        n_total++; if (n_multi !== 0) $display("FAIL all4_onehot: got %0d multi-hot cycles expected 0", n_multi); else n_pass++;
    endtask

    task automatic test_reject();
        rsp_t r;
        clear();
        req_idx[1*IDX_W +: IDX_W] = 10'd25;
        req_valid[1] = 1'b1;
        wait_rsp(1, 3, "reject");
        r = rsp_at(0);
        n_total++; if (r.owner !== 1)     $display("FAIL reject_owner: got %0d expected 1", r.owner); else n_pass++;
        n_total++; if (r.err !== 1'b1)    $display("FAIL reject_err: got %b expected 1", r.err); else n_pass++;
        n_total++; if (r.data !== 16'd0)  $display("FAIL reject_data: got %0d expected 0", r.data); else n_pass++;
        repeat (5) step();
        n_total++; if (n_ack[1] !== 1)    $display("FAIL reject_ack_count: got %0d expected 1", n_ack[1]); else n_pass++;
        n_total++; if (n_start !== 0)     $display("FAIL reject_start_count: got %0d expected 0", n_start); else n_pass++;
    endtask

    task automatic test_timeout();
        rsp_t r;
        clear();
        eng_hang = 1'b1;
        req_idx[0*IDX_W +: IDX_W] = 10'd7;
        req_valid[0] = 1'b1;
        wait_rsp(1, 400, "timeout");
        r = rsp_at(0);
        n_total++; if (r.owner !== 0)      $display("FAIL timeout_owner: got %0d expected 0", r.owner); else n_pass++;
        n_total++; if (r.err !== 1'b1)     $display("FAIL timeout_err: got %b expected 1", r.err); else n_pass++;
        n_total++; if (r.data !== 16'd0)   $display("FAIL timeout_data: got %0d expected 0", r.data); else n_pass++;
        n_total++; if (n_frst_low !== 2)   $display("FAIL timeout_fibo_rst_low: got %0d cycles expected 2", n_frst_low); else n_pass++;
        n_total++; if (n_start !== 1)      $display("FAIL timeout_start_count: got %0d expected 1", n_start); else n_pass++;
        eng_hang = 1'b0;
    endtask

    task automatic test_done_at_timeout();
        rsp_t r;
        clear();
        eng_lat = 255;
        req_idx[3*IDX_W +: IDX_W] = 10'd12;
        req_valid[3] = 1'b1;
        wait_rsp(1, 400, "edge255");
        r = rsp_at(0);
        n_total++; if (r.err !== 1'b0 || r.data !== 16'd144) $display("FAIL edge255_rsp: got err %b data %0d expected err 0 data 144", r.err, r.data); else n_pass++;
        n_total++; if (n_frst_low !== 0) $display("FAIL edge255_fibo_rst_low: got %0d cycles expected 0", n_frst_low); else n_pass++;
        clear();
        eng_lat = 256;
        req_valid[3] = 1'b1;
        wait_rsp(1, 400, "edge256");
        r = rsp_at(0);
        n_total++; if (r.err !== 1'b1 || r.data !== 16'd0) $display("FAIL edge256_rsp: got err %b data %0d expected err 1 data 0", r.err, r.data); else n_pass++;
        n_total++; if (n_frst_low !== 2) $display("FAIL edge256_fibo_rst_low: got %0d cycles expected 2", n_frst_low); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rsp_t r;
        clear();
        eng_lat = 20;
        req_idx[2*IDX_W +: IDX_W] = 10'd15;
        req_valid[2] = 1'b1;
        repeat (6) step();
        n_total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || fibo_start !== 1'b0 || fibo_rst !== 1'b0)
            $display("FAIL midrst_ctrl: got busy %b start %b fibo_rst %b expected 0 0 0", busy, fibo_start, fibo_rst); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0 || req_ack !== 4'b0 || rsp_data !== 16'd0 || fibo_idx !== 10'd0)
            $display("FAIL midrst_data: got rsp_valid %b ack %b data %0d idx %0d expected all 0", rsp_valid, req_ack, rsp_data, fibo_idx); else n_pass++;
        req_valid = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (30) step();
        n_total++; if (n_rsp !== 0) $display("FAIL midrst_no_rsp: got %0d responses expected 0", n_rsp); else n_pass++;
        req_valid[2] = 1'b1;
        wait_rsp(1, 60, "midrst_retry");
        r = rsp_at(0);
        n_total++; if (r.owner !== 2 || r.data !== 16'd610 || r.err !== 1'b0)
            $display("FAIL midrst_retry_rsp: got owner %0d data %0d err %b expected owner 2 data 610 err 0", r.owner, r.data, r.err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_reject();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
